// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//   Shares one memory/IO bus between the CPU data port (m0) and a second
//   master (m1). The arbiter latches the winning request and drives a
//   req/ready handshake to the slave. Read data comes back with a one-cycle
//   ack pulse. A transfer that sees no s_ready for TIMEOUT cycles is aborted
//   with err.
//
//   Ports
//     clk, rst_n                  clock, asynchronous active-low reset
//     mX_req/addr/ctrl/wd         requester X: request held until ack, payload
//     mX_ack/err/rd               requester X: completion pulse, timeout
//                                 flag, read data (valid with ack)
//     s_req/addr/ctrl/wd/we       slave side: request and latched payload
//     s_rd, s_ready               slave side: read data and completion
//     grant                       owner of current/last transfer (1 = m1)
//     busy                        transfer in progress (XFER or DONE)
//
//   State | meaning
//   IDLE  | waiting for a request; arbitrates and latches payload
//   XFER  | s_req high, waiting for s_ready or timeout
//   DONE  | ack (and err) pulse to the granted requester
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int CTRL_W      = 4,
    parameter bit ROUND_ROBIN = 1'b1,
    parameter int TIMEOUT     = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [CTRL_W-1:0] m0_ctrl,
    input  logic [DATA_W-1:0] m0_wd,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rd,

    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [CTRL_W-1:0] m1_ctrl,
    input  logic [DATA_W-1:0] m1_wd,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rd,

    output logic              s_req,
    output logic [ADDR_W-1:0] s_addr,
    output logic [CTRL_W-1:0] s_ctrl,
    output logic [DATA_W-1:0] s_wd,
    output logic              s_we,
    input  logic [DATA_W-1:0] s_rd,
    input  logic              s_ready,

    output logic              grant,
    output logic              busy
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rdata;
    logic              pick_m1;

    // m1 wins when it is the only requester, or on a tie when round-robin
    // is enabled and m0 owned the previous transfer.
    assign pick_m1 = m1_req && (!m0_req || (ROUND_ROBIN && !grant));

    assign s_we  = s_req & s_ctrl[0];
    assign m0_rd = rdata;
    assign m1_rd = rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            rdata  <= '0;
            s_req  <= 1'b0;
            s_addr <= '0;
            s_ctrl <= '0;
            s_wd   <= '0;
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            m0_err <= 1'b0;
            m1_err <= 1'b0;
            busy   <= 1'b0;
            // Starting at m1 makes the first tie go to m0 under round-robin.
            grant  <= 1'b1;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            m0_err <= 1'b0;
            m1_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        grant  <= pick_m1;
                        s_addr <= pick_m1 ? m1_addr : m0_addr;
                        s_ctrl <= pick_m1 ? m1_ctrl : m0_ctrl;
                        s_wd   <= pick_m1 ? m1_wd   : m0_wd;
                        s_req  <= 1'b1;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        state  <= XFER;
                    end
                end
                XFER: begin
                    // s_ready takes priority over an expiring counter.
                    if (s_ready) begin
                        rdata  <= s_rd;
                        s_req  <= 1'b0;
                        m0_ack <= !grant;
                        m1_ack <= grant;
                        state  <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        rdata  <= '0;
                        s_req  <= 1'b0;
                        m0_ack <= !grant;
                        m1_ack <= grant;
                        m0_err <= !grant;
                        m1_err <= grant;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    s_req <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//   Scoreboard bench. Each round issues requests and predicts at transaction
//   level which master is served in what order, what the slave must see, and
//   what the ack must return. A monitor checks the bus and the acks against
//   the queued predictions. A slave model answers after a chosen delay.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int T  = 16;
    localparam bit RR = 1'b1;

    logic        clk, rst_n;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m1_addr, m0_wd, m1_wd;
    logic [3:0]  m0_ctrl, m1_ctrl;
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic [31:0] m0_rd, m1_rd;
    logic        s_req, s_we, s_ready;
    logic [31:0] s_addr, s_wd, s_rd;
    logic [3:0]  s_ctrl;
    logic        grant, busy;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .CTRL_W(4),
                      .ROUND_ROBIN(RR), .TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_ctrl(m0_ctrl), .m0_wd(m0_wd),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rd(m0_rd),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_ctrl(m1_ctrl), .m1_wd(m1_wd),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rd(m1_rd),
        .s_req(s_req), .s_addr(s_addr), .s_ctrl(s_ctrl), .s_wd(s_wd),
        .s_we(s_we), .s_rd(s_rd), .s_ready(s_ready),
        .grant(grant), .busy(busy)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  ctrl;
        logic [31:0] wd;
        logic        port;
    } bus_t;

    typedef struct {
        logic        port;
        logic [31:0] rd;
        logic        err;
        int          cycles;
    } resp_t;

    typedef struct {
        int          delay;
        logic [31:0] data;
    } slv_t;

    bus_t  bus_q[$];
    resp_t resp_q[$];
    slv_t  slv_q[$];

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;
    logic lg;   // model's last grant

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave model: answers the n-th transfer at XFER cycle 'delay' (0-based);
    // delays >= T never answer. Outside XFER it drives random noise.
    initial begin : slave
        bit   active;
        int   cnt;
        slv_t cur;
        active  = 1'b0;
        cnt     = 0;
        cur     = '{1000, 32'h0};
        s_ready = 1'b0;
        s_rd    = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active  = 1'b0;
                s_ready = 1'b0;
            end else if (s_req) begin
                if (!active) begin
                    active = 1'b1;
                    cnt    = 0;
                    if (slv_q.size() > 0) cur = slv_q.pop_front();
                    else cur = '{1000, 32'h0};
                end
                s_ready = (cnt == cur.delay);
                s_rd    = (cnt == cur.delay) ? cur.data : $urandom;
                cnt++;
            end else begin
                active  = 1'b0;
                s_ready = 1'($urandom_range(0, 1));
                s_rd    = $urandom;
            end
        end
    end

    // Monitor: checks latched payload at transfer start, stability during
    // XFER, XFER length and the ack response.
    initial begin : monitor
        bit    prev_sreq;
        int    xcnt;
        bus_t  cb;
        resp_t cr;
        prev_sreq = 1'b0;
        xcnt      = 0;
        cb        = '{32'h0, 4'h0, 32'h0, 1'b0};
        forever begin
            @(negedge clk);
            if (!mon_en || !rst_n) begin
                prev_sreq = 1'b0;
            end else begin
                if (s_req && !prev_sreq) begin
                    xcnt = 0;
                    if (bus_q.size() == 0) begin
                        chk("unexpected_xfer", 64'(bus_q.size()), 64'd1);
                    end else begin
                        cb = bus_q.pop_front();
                        chk("grant", grant, cb.port);
                        chk("s_ctrl", s_ctrl, cb.ctrl);
                        chk("s_wd", s_wd, cb.wd);
                        chk("busy_xfer", busy, 1'b1);
                    end
                end
                if (s_req) begin
                    xcnt++;
                    chk("s_addr", s_addr, cb.addr);
                    chk("s_we", s_we, cb.ctrl[0]);
                end
                if (m0_ack || m1_ack) begin
                    chk("ack_onehot", m0_ack & m1_ack, 1'b0);
                    if (resp_q.size() == 0) begin
                        chk("unexpected_ack", 64'(resp_q.size()), 64'd1);
                    end else begin
                        cr = resp_q.pop_front();
                        chk("ack_port", m1_ack, cr.port);
                        chk("rd", cr.port ? m1_rd : m0_rd, cr.rd);
                        chk("err", cr.port ? m1_err : m0_err, cr.err);
                        chk("other_err", cr.port ? m0_err : m1_err, 1'b0);
                        chk("xfer_cycles", 64'(xcnt), 64'(cr.cycles));
                        chk("s_req_done", s_req, 1'b0);
                        chk("busy_done", busy, 1'b1);
                    end
                end
                prev_sreq = s_req;
            end
        end
    end

    // One round: issue the given requests, predict service order and result,
    // keep each request up until its ack, and scramble the payload of the
    // master being served while its transfer is in flight.
    task automatic do_round(input bit r0, input bit r1,
                            input logic [31:0] a0, input logic [3:0] c0, input logic [31:0] w0,
                            input logic [31:0] a1, input logic [3:0] c1, input logic [31:0] w1,
                            input int d0, input logic [31:0] rd0,
                            input int d1, input logic [31:0] rd1);
        bit          order[2];
        int          n, acks, d;
        logic [31:0] dat;
        logic        p;
        if (r0 && r1) begin
            order[0] = RR ? !lg : 1'b0;
            order[1] = !order[0];
            n = 2;
        end else begin
            order[0] = r1;
            order[1] = r1;
            n = (r0 || r1) ? 1 : 0;
        end
        for (int k = 0; k < n; k++) begin
            p   = order[k];
            d   = (k == 0) ? d0 : d1;
            dat = (k == 0) ? rd0 : rd1;
            bus_q.push_back('{p ? a1 : a0, p ? c1 : c0, p ? w1 : w0, p});
            slv_q.push_back('{d, dat});
            resp_q.push_back('{p, (d < T) ? dat : 32'h0, (d >= T), (d < T) ? d + 1 : T});
            lg = p;
        end
        @(negedge clk);
        m0_req = r0; m0_addr = a0; m0_ctrl = c0; m0_wd = w0;
        m1_req = r1; m1_addr = a1; m1_ctrl = c1; m1_wd = w1;
        acks = 0;
        for (int cyc = 0; cyc < 200 && acks < n; cyc++) begin
            @(negedge clk);
            if (m0_ack) begin m0_req = 1'b0; acks++; end
            if (m1_ack) begin m1_req = 1'b0; acks++; end
            if (!m0_ack && !m1_ack && s_req && acks < n) begin
                if (order[acks]) begin
                    m1_addr = $urandom; m1_ctrl = 4'($urandom); m1_wd = $urandom;
                end else begin
                    m0_addr = $urandom; m0_ctrl = 4'($urandom); m0_wd = $urandom;
                end
            end
        end
        if (acks < n) chk("round_timeout", 64'(acks), 64'(n));
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    function automatic int rand_delay();
        int sel;
        sel = int'($urandom_range(0, 9));
        if (sel < 6) return int'($urandom_range(0, 4));
        if (sel == 6) return T - 1;
        if (sel == 7) return T - 2;
        return T + 5;
    endfunction

    initial begin : stim
        bit r0, r1;
        lg      = 1'b1;
        rst_n   = 1'b0;
        m0_req  = 1'b0; m0_addr = '0; m0_ctrl = '0; m0_wd = '0;
        m1_req  = 1'b0; m1_addr = '0; m1_ctrl = '0; m1_wd = '0;
        #12;
        chk("rst_s_req", s_req, 1'b0);
        chk("rst_s_we", s_we, 1'b0);
        chk("rst_s_addr", s_addr, 32'h0);
        chk("rst_acks", {m0_ack, m1_ack, m0_err, m1_err}, 4'h0);
        chk("rst_rd", m0_rd, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant", grant, 1'b1);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // single read, answer on 2nd XFER cycle
        do_round(1, 0, 32'h0000_1000, 4'b0100, 32'h0, 32'h0, 4'h0, 32'h0,
                 1, 32'h1234_5678, 0, 32'h0);
        // write from m1, answer on 1st XFER cycle
        do_round(0, 1, 32'h0, 4'h0, 32'h0, 32'h8000_0010, 4'b0101, 32'hCAFE_F00D,
                 0, 32'h0BAD_0BAD, 0, 32'h0);
        // m0 times out while m1 is pending
        do_round(1, 1, 32'h0000_0100, 4'b0100, 32'h0, 32'h0000_0200, 4'b0100, 32'h0,
                 T + 5, 32'hDEAD_BEEF, 2, 32'h7777_0001);
        // ready on the expiring cycle completes normally
        do_round(1, 0, 32'h0000_0300, 4'b0010, 32'h0, 32'h0, 4'h0, 32'h0,
                 T - 1, 32'h5A5A_A5A5, 0, 32'h0);
        // continuous ties alternate
        for (int i = 0; i < 3; i++)
            do_round(1, 1, $urandom, 4'($urandom), $urandom, $urandom, 4'($urandom), $urandom,
                     int'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 3)), $urandom);

        for (int i = 0; i < 40; i++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1'b1;
            do_round(r0, r1, $urandom, 4'($urandom), $urandom, $urandom, 4'($urandom), $urandom,
                     rand_delay(), $urandom, rand_delay(), $urandom);
        end

        // asynchronous reset in the middle of a transfer
        mon_en = 1'b0;
        slv_q.push_back('{T + 5, 32'h0});
        @(negedge clk);
        m0_req = 1'b1; m0_addr = 32'h55; m1_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_rst_s_req", s_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_s_req", s_req, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_acks", {m0_ack, m1_ack}, 2'b00);
        chk("async_rst_grant", grant, 1'b1);
        m0_req = 1'b0; m1_req = 1'b0;
        @(negedge clk);
        bus_q.delete(); resp_q.delete(); slv_q.delete();
        rst_n  = 1'b1;
        lg     = 1'b1;
        mon_en = 1'b1;
        do_round(1, 1, 32'h0000_0A00, 4'b0100, 32'h0, 32'h0000_0B00, 4'b0101, 32'h1,
                 0, 32'h1111_2222, 1, 32'h3333_4444);

        repeat (4) @(negedge clk);
        chk("bus_q_drained", 64'(bus_q.size()), 64'd0);
        chk("resp_q_drained", 64'(resp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
